// File: rtl/nvram_upload_ctrl.sv
// HPS save/restore controller for the 2^AW-byte EAROM/NVRAM shadow.
// Halts the CPU for the whole ioctl session, serves byte reads/writes and tracks a dirty flag.
module nvram_upload_ctrl #(
   parameter int          AW       = 6,
   parameter logic [7:0]  NV_INDEX = 8'd4,
   parameter int          RD_LAT   = 1
) (
   input  logic          clk_i,
   input  logic          btnCpuReset,
   input  logic          ioctl_upload,
   input  logic          ioctl_download,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_rd,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic          cpu_pause,
   input  logic          cpu_paused,
   input  logic          cpu_nv_wr,
   output logic [AW-1:0] nv_addr,
   output logic          nv_we,
   output logic [7:0]    nv_wdata,
   input  logic [7:0]    nv_rdata,
   output logic          nv_dirty
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HOLD    = 3'd1;
   localparam logic [2:0] S_ACTIVE  = 3'd2;
   localparam logic [2:0] S_READ    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam logic [AW:0] COV_FULL = {1'b1, {AW{1'b0}}};

   typedef struct packed {
      logic        vld;
      logic        rd;
      logic [24:0] addr;
      logic [7:0]  data;
   } nv_req_t;

   logic [2:0]        state;
   logic              is_up;
   logic              wrote;
   logic [AW:0]       cov;
   logic [RD_LAT-1:0] vld_pipe;
   nv_req_t           pend;
   nv_req_t           live;
   nv_req_t           req;
   logic              sess, go, in_rng, rel, rel_clr;

   assign sess = (ioctl_upload | ioctl_download) && (ioctl_index == NV_INDEX);

   // Only strobes that match the session direction are considered at all.
   always_comb begin
      live      = '0;
      live.rd   = sess & ioctl_rd & is_up;
      live.vld  = live.rd | (sess & ioctl_wr & ~is_up);
      live.addr = ioctl_addr;
      live.data = ioctl_dout;
   end

   // A fresh strobe overrides whatever was parked while waiting for the CPU.
   assign req     = live.vld ? live : pend;
   assign in_rng  = ~|req.addr[24:AW];
   assign go      = sess && ((state == S_ACTIVE) || ((state == S_HOLD) && cpu_paused));
   assign rel     = !sess && ((state == S_HOLD) || (state == S_ACTIVE));
   assign rel_clr = rel && (is_up ? (cov == COV_FULL) : wrote);

   always_ff @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         state      <= S_IDLE;
         ioctl_din  <= 8'hFF;
         ioctl_wait <= 1'b0;
         cpu_pause  <= 1'b0;
         nv_addr    <= '0;
         nv_we      <= 1'b0;
         nv_wdata   <= '0;
         nv_dirty   <= 1'b0;
         is_up      <= 1'b0;
         wrote      <= 1'b0;
         cov        <= '0;
         vld_pipe   <= '0;
         pend       <= '0;
      end else begin
         nv_we <= 1'b0;

         case (state)
            S_IDLE: begin
               if (sess) begin
                  state      <= S_HOLD;
                  cpu_pause  <= 1'b1;
                  ioctl_wait <= 1'b1;
                  is_up      <= ioctl_upload;
                  wrote      <= 1'b0;
                  cov        <= '0;
                  pend       <= '0;
               end
            end
            S_HOLD: begin
               if (!sess) begin
                  state      <= S_RELEASE;
                  ioctl_wait <= 1'b0;
                  pend       <= '0;
               end else if (!cpu_paused && live.vld) begin
                  pend <= live;
               end
            end
            S_ACTIVE: begin
               if (!sess) state <= S_RELEASE;
            end
            S_READ: begin
               vld_pipe <= vld_pipe << 1;
               if (vld_pipe[RD_LAT-1]) begin
                  ioctl_din  <= nv_rdata;
                  ioctl_wait <= 1'b0;
                  state      <= S_ACTIVE;
               end
            end
            S_RELEASE: begin
               cpu_pause <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Shared service path: a live strobe in ACTIVE, or the parked one on entry to ACTIVE.
         if (go) begin
            pend.vld   <= 1'b0;
            state      <= S_ACTIVE;
            ioctl_wait <= 1'b0;
            if (req.vld) begin
               if (req.rd) begin
                  if (in_rng) begin
                     nv_addr    <= req.addr[AW-1:0];
                     ioctl_wait <= 1'b1;
                     vld_pipe   <= RD_LAT'(1);
                     state      <= S_READ;
                     if (cov == {1'b0, req.addr[AW-1:0]}) cov <= cov + 1'b1;
                  end else begin
                     ioctl_din <= 8'hFF;
                  end
               end else if (in_rng) begin
                  nv_addr  <= req.addr[AW-1:0];
                  nv_wdata <= req.data;
                  nv_we    <= 1'b1;
                  wrote    <= 1'b1;
               end
            end
         end

         if (rel_clr)   nv_dirty <= 1'b0;
         if (cpu_nv_wr) nv_dirty <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// Directed bench for nvram_upload_ctrl: session handshake, reads, writes, dirty flag, async reset.
module tb_nvram_upload_ctrl;

   logic        clk_i, btnCpuReset;
   logic        ioctl_upload, ioctl_download, ioctl_rd, ioctl_wr;
   logic [7:0]  ioctl_index, ioctl_dout, ioctl_din, nv_wdata, nv_rdata;
   logic [24:0] ioctl_addr;
   logic        ioctl_wait, cpu_pause, cpu_paused, cpu_nv_wr, nv_we, nv_dirty;
   logic [5:0]  nv_addr;

   logic [7:0]  mem [64];
   int          we_cnt;
   int          n_chk, n_err;

   nvram_upload_ctrl #(.AW(6), .NV_INDEX(8'd4), .RD_LAT(1)) dut (
      .clk_i(clk_i), .btnCpuReset(btnCpuReset),
      .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
      .ioctl_wait(ioctl_wait), .cpu_pause(cpu_pause), .cpu_paused(cpu_paused),
      .cpu_nv_wr(cpu_nv_wr), .nv_addr(nv_addr), .nv_we(nv_we),
      .nv_wdata(nv_wdata), .nv_rdata(nv_rdata), .nv_dirty(nv_dirty)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // RAM model with one-cycle read latency; reloaded with i^5A while in reset.
   assign nv_rdata = mem[nv_addr];
   always @(posedge clk_i or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i) ^ 8'h5A;
         we_cnt <= 0;
      end else if (nv_we) begin
         mem[nv_addr] <= nv_wdata;
         we_cnt       <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_rd(input int a, input logic in_rng);
      logic [7:0] exp_d;
      logic [5:0] na;
      exp_d = in_rng ? (8'(a) ^ 8'h5A) : 8'hFF;
      na    = nv_addr;
      ioctl_rd = 1'b1; ioctl_addr = 25'(a);
      tick();
      ioctl_rd = 1'b0;
      if (in_rng) begin
         chk("rd_wait_hi", 32'(ioctl_wait), 32'd1);
         chk("rd_naddr", 32'(nv_addr), 32'(a[5:0]));
         tick();
         chk("rd_wait_lo", 32'(ioctl_wait), 32'd0);
         chk("rd_din", 32'(ioctl_din), 32'(exp_d));
      end else begin
         chk("oor_wait", 32'(ioctl_wait), 32'd0);
         chk("oor_din", 32'(ioctl_din), 32'hFF);
         chk("oor_naddr", 32'(nv_addr), 32'(na));
         tick();
         chk("oor_wait2", 32'(ioctl_wait), 32'd0);
      end
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      btnCpuReset = 1'b0;
      ioctl_upload = 0; ioctl_download = 0; ioctl_index = 0; ioctl_rd = 0; ioctl_wr = 0;
      ioctl_addr = 0; ioctl_dout = 0; cpu_paused = 0; cpu_nv_wr = 0;
      #12;
      chk("rst_din", 32'(ioctl_din), 32'hFF);
      chk("rst_pause", 32'(cpu_pause), 32'd0);
      chk("rst_wait", 32'(ioctl_wait), 32'd0);
      chk("rst_dirty", 32'(nv_dirty), 32'd0);
      chk("rst_we", 32'(nv_we), 32'd0);
      @(negedge clk_i) btnCpuReset = 1'b1;
      tick();

      // 1: session start, CPU acks after 5 cycles
      ioctl_upload = 1; ioctl_index = 8'd4;
      #1 chk("t1_pause_pre", 32'(cpu_pause), 32'd0);
      tick();
      chk("t1_pause", 32'(cpu_pause), 32'd1);
      chk("t1_wait", 32'(ioctl_wait), 32'd1);
      repeat (4) begin
         tick();
         chk("t1_hold_wait", 32'(ioctl_wait), 32'd1);
         chk("t1_hold_naddr", 32'(nv_addr), 32'd0);
         chk("t1_hold_we", 32'(we_cnt), 32'd0);
      end
      cpu_paused = 1;
      tick();
      chk("t1_act_wait", 32'(ioctl_wait), 32'd0);
      chk("t1_act_pause", 32'(cpu_pause), 32'd1);

      // 4a: CPU dirties the shadow
      cpu_nv_wr = 1; tick(); cpu_nv_wr = 0;
      chk("t4_dirty_set", 32'(nv_dirty), 32'd1);

      // 2: full in-range upload
      for (int a = 0; a < 64; a++) do_rd(a, 1'b1);
      // 3: out-of-range reads
      do_rd(64, 1'b0);
      do_rd(1000, 1'b0);
      chk("t4_dirty_hold", 32'(nv_dirty), 32'd1);

      // 4b: release after full upload clears dirty, pause drops a cycle later
      ioctl_upload = 0;
      tick();
      chk("t4_dirty_clr", 32'(nv_dirty), 32'd0);
      chk("t4_pause_rel", 32'(cpu_pause), 32'd1);
      tick();
      chk("t4_pause_off", 32'(cpu_pause), 32'd0);

      // 4c: partial upload keeps dirty
      ioctl_upload = 1; tick(); tick();
      cpu_nv_wr = 1; tick(); cpu_nv_wr = 0;
      for (int a = 0; a < 63; a++) do_rd(a, 1'b1);
      ioctl_upload = 0; tick(); tick();
      chk("t4_partial_dirty", 32'(nv_dirty), 32'd1);
      chk("t4_partial_pause", 32'(cpu_pause), 32'd0);

      // 5: download on index 4
      ioctl_download = 1; tick(); tick();
      ioctl_wr = 1; ioctl_addr = 25'd3; ioctl_dout = 8'hC3;
      tick(); ioctl_wr = 0;
      chk("t5_we", 32'(nv_we), 32'd1);
      chk("t5_naddr", 32'(nv_addr), 32'd3);
      chk("t5_wdata", 32'(nv_wdata), 32'hC3);
      tick();
      chk("t5_we_pulse", 32'(nv_we), 32'd0);
      ioctl_wr = 1; ioctl_addr = 25'd70; ioctl_dout = 8'h77;
      tick(); ioctl_wr = 0;
      chk("t5_oor_we", 32'(nv_we), 32'd0);
      ioctl_rd = 1; ioctl_addr = 25'd5;
      tick(); ioctl_rd = 0;
      chk("t5_rd_ignored", 32'(ioctl_wait), 32'd0);
      ioctl_download = 0;
      tick();
      chk("t5_dirty_clr", 32'(nv_dirty), 32'd0);
      tick();
      chk("t5_pause_off", 32'(cpu_pause), 32'd0);
      chk("t5_we_cnt", 32'(we_cnt), 32'd1);
      chk("t5_mem3", 32'(mem[3]), 32'hC3);

      // 5b: same stimulus on index 0 does nothing
      cpu_nv_wr = 1; tick(); cpu_nv_wr = 0;
      ioctl_index = 8'd0; ioctl_download = 1; tick();
      chk("t5b_pause", 32'(cpu_pause), 32'd0);
      ioctl_wr = 1; ioctl_addr = 25'd3; ioctl_dout = 8'h11;
      tick(); ioctl_wr = 0;
      chk("t5b_we", 32'(nv_we), 32'd0);
      ioctl_wr = 1; ioctl_addr = 25'd70;
      tick(); ioctl_wr = 0; tick();
      chk("t5b_pause2", 32'(cpu_pause), 32'd0);
      ioctl_download = 0; tick();
      chk("t5b_we_cnt", 32'(we_cnt), 32'd1);
      chk("t5b_dirty", 32'(nv_dirty), 32'd1);

      // 6: read strobed during HOLD, then reset mid-READ
      cpu_paused = 0; ioctl_index = 8'd4; ioctl_upload = 1;
      tick();
      chk("t6_pause", 32'(cpu_pause), 32'd1);
      ioctl_rd = 1; ioctl_addr = 25'd5;
      tick(); ioctl_rd = 0;
      chk("t6_hold_wait", 32'(ioctl_wait), 32'd1);
      chk("t6_hold_naddr", 32'(nv_addr), 32'd3);
      tick();
      cpu_paused = 1;
      tick();
      chk("t6_pend_wait", 32'(ioctl_wait), 32'd1);
      chk("t6_pend_naddr", 32'(nv_addr), 32'd5);
      tick();
      chk("t6_pend_wait0", 32'(ioctl_wait), 32'd0);
      chk("t6_pend_din", 32'(ioctl_din), 32'h5F);
      ioctl_rd = 1; ioctl_addr = 25'd7;
      tick(); ioctl_rd = 0;
      chk("t6_read_wait", 32'(ioctl_wait), 32'd1);
      #2 btnCpuReset = 0;
      #1;
      chk("t6_rst_pause", 32'(cpu_pause), 32'd0);
      chk("t6_rst_wait", 32'(ioctl_wait), 32'd0);
      chk("t6_rst_din", 32'(ioctl_din), 32'hFF);
      chk("t6_rst_dirty", 32'(nv_dirty), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/nvram_upload_ctrl.md
Name: nvram_upload_ctrl

Overview:
- Services the HPS save/restore path for the game's 64-byte EAROM/NVRAM shadow (high scores, settings).
- Upload: the HPS reads the shadow out through ioctl_upload/ioctl_rd/ioctl_din. Restore: the HPS writes it back through ioctl_download/ioctl_wr.
- Sits between hps_io and the EAROM shadow RAM port, alongside the ROM download path. Pauses the CPU for the whole session and tracks a dirty flag that prompts a save.

Parameters:
- AW, 6, NVRAM address width (2^AW bytes).
- NV_INDEX, 4, ioctl_index value selecting NVRAM for both upload and download.
- RD_LAT, 1, NVRAM read latency in clk_i cycles (1..3).

Ports:
- clk_i  in  1  system clock (clk_50 domain).
- btnCpuReset  in  1  asynchronous, active-low reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_download  in  1  HPS download session active.
- ioctl_index  in  8  session target index.
- ioctl_rd  in  1  single-cycle read strobe.
- ioctl_wr  in  1  single-cycle write strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  write data from HPS.
- ioctl_din  out  8  read data to HPS.
- ioctl_wait  out  1  stalls the HPS.
- cpu_pause  out  1  request to halt the CPU.
- cpu_paused  in  1  CPU halted acknowledge.
- cpu_nv_wr  in  1  CPU wrote the EAROM (pulse).
- nv_addr  out  AW  NVRAM address.
- nv_we  out  1  NVRAM write enable.
- nv_wdata  out  8  NVRAM write data.
- nv_rdata  in  8  NVRAM read data.
- nv_dirty  out  1  shadow modified since the last full save or restore.

Behaviour:
- Reset (async, btnCpuReset=0):
  - State IDLE.
  - All outputs 0 except ioctl_din=8'hFF.
  - Pending request cleared, read-coverage counter cleared.
- sess = (ioctl_upload | ioctl_download) & (ioctl_index==NV_INDEX). Strobes are ignored when sess=0.
- FSM states:
  - IDLE: sess rises -> HOLD.
  - HOLD: cpu_pause=1, ioctl_wait=1. Stays until cpu_paused=1, then -> ACTIVE. If sess drops first -> RELEASE; any pending request is dropped.
  - ACTIVE: cpu_pause=1. Serves strobes. sess=0 -> RELEASE.
  - READ: ioctl_wait=1 for RD_LAT cycles. Then ioctl_din<=nv_rdata, ioctl_wait<=0, -> ACTIVE.
  - RELEASE: cpu_pause<=0 on the next edge, -> IDLE.
- Strobe arriving during HOLD: latched as a single pending request (addr, data, rd/wr) and executed on entry to ACTIVE. A second strobe during HOLD overwrites the first; this is legal because ioctl_wait is high.
- Read in ACTIVE, addr < 2^AW:
  - nv_addr<=addr[AW-1:0]; ioctl_wait rises on the same edge; -> READ.
  - Total strobe-to-data latency is RD_LAT+1 cycles.
- Read in ACTIVE, addr >= 2^AW: ioctl_din<=8'hFF next cycle, no RAM access, no wait.
- Write in ACTIVE (download session only), addr < 2^AW: nv_addr/nv_wdata registered, nv_we pulses exactly one cycle. Out-of-range writes are dropped.
- Strobe type mismatched to the session (rd in download, wr in upload): ignored.
- Coverage counter increments on each in-range upload read whose address equals the counter value; it saturates at 2^AW.
- nv_dirty:
  - Set by cpu_nv_wr in any state.
  - Cleared at RELEASE of an upload session where the counter reached 2^AW.
  - Cleared at RELEASE of a download session that wrote at least one byte.
  - cpu_nv_wr in the same cycle as a clear: set wins.
- ioctl_din holds its last value between reads.
- Reset mid-session: everything returns to reset values immediately. cpu_pause drops asynchronously.

Test Plan:
1. Reset, then sess upload index 4, cpu_paused after 5 cycles -> cpu_pause=1 from the cycle after sess; ioctl_wait=1 until ACTIVE; no nv access before cpu_paused.
2. Preload RAM[i]=i^8'h5A, upload read addr 0..63 with RD_LAT=1 -> each ioctl_din==addr^8'h5A exactly 2 cycles after ioctl_rd; ioctl_wait high exactly 1 cycle per read.
3. Upload read addr 64 and 1000 -> ioctl_din=8'hFF one cycle later, ioctl_wait never rises, nv_addr unchanged.
4. cpu_nv_wr pulse, then full 0..63 upload, then sess drop -> nv_dirty=1 until RELEASE, then 0, and cpu_pause=0 one cycle later; a partial upload (0..62) leaves nv_dirty=1.
5. Download index 4 writing addr 3=8'hC3 plus addr 70 -> a single nv_we pulse with nv_addr=3, nv_wdata=8'hC3; nv_dirty cleared at RELEASE. Same stimulus with index 0 -> no nv_we, cpu_pause stays 0.
6. ioctl_rd during HOLD, then btnCpuReset low mid-READ -> pending read executes on entry to ACTIVE; on reset, cpu_pause and ioctl_wait go 0 and ioctl_din goes 8'hFF without waiting for a clock edge.
